// File: rtl/conv_frame_encoder_pkg.sv
// Shared definitions for the K=3 rate-1/2 convolutional code (encoder and viterbi_decoder).
// Latency: n/a (constants, types and a combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   CONV_DATA_W  default information bits per frame
//   CONV_K       constraint length (2 state bits + current input)
//   CONV_G0/G1   generator polynomials, bit2 taps the current input u
//   conv_state_e frame FSM state {IDLE, ENC, DONE}
//   conv_branch  {u,s1,s2} -> {c0,c1} for the default generators
package conv_pkg;

    localparam int       CONV_DATA_W = 8;
    localparam int       CONV_K      = 3;
    localparam logic [2:0] CONV_G0   = 3'b111;
    localparam logic [2:0] CONV_G1   = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        DONE = 2'd2
    } conv_state_e;

    // Branch output for one trellis step: the register vector is ordered
    // {u, s1, s2} so generator bit2 always taps the newest bit.
    function automatic logic [1:0] conv_branch(input logic u,
                                               input logic s1,
                                               input logic s2);
        logic [2:0] reg_v;
        reg_v = {u, s1, s2};
        return {^(reg_v & CONV_G0), ^(reg_v & CONV_G1)};
    endfunction

endpackage : conv_pkg

// File: rtl/conv_frame_encoder_bit_step.sv
// One trellis step of the K=3 rate-1/2 code: {u,s1,s2} -> {c0,c1} and next {s1,s2}.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the step is committed.
//
// Ports:
//   u_i, s1_i, s2_i   current input bit and shift-register state (s1 = newest)
//   c0_o, c1_o        code bits for generators G0 and G1
//   s1_nxt_o/s2_nxt_o state after shifting u in
module conv_bit_step
    import conv_pkg::*;
#(
    parameter logic [2:0] G0 = CONV_G0,
    parameter logic [2:0] G1 = CONV_G1
) (
    input  logic u_i,
    input  logic s1_i,
    input  logic s2_i,
    output logic c0_o,
    output logic c1_o,
    output logic s1_nxt_o,
    output logic s2_nxt_o
);

    logic [2:0] reg_v;

    assign reg_v    = {u_i, s1_i, s2_i};
    assign c0_o     = ^(reg_v & G0);
    assign c1_o     = ^(reg_v & G1);
    // Shift: the oldest bit s2 falls off, u becomes the newest state bit.
    assign s1_nxt_o = u_i;
    assign s2_nxt_o = s1_i;

endmodule : conv_bit_step

// File: rtl/conv_frame_encoder.sv
// Frame-based rate-1/2 K=3 convolutional encoder, MSB first, zero start state per frame.
// Latency: accept at edge T0, o_done high after edge T(DATA_W), o_ready back after T(DATA_W+1).
// Backpressure: o_ready low while busy; i_valid is ignored (source holds) until IDLE; en=0 freezes all.
//
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset (wins over en)
//   en          global enable; low holds FSM, counter, shift register and outputs
//   i_valid     i_data valid, accepted when o_ready & en
//   o_ready     encoder idle
//   i_data      information frame, bit DATA_W-1 encoded first
//   o_data      codeword, pair k at bits [2*DATA_W-1-2k -: 2] = {c0,c1}
//   o_done      codeword-valid strobe, one enabled cycle wide
//   i_err_mask  (only with ERR_INJECT_EN) XORed onto the codeword to model channel errors
module conv_frame_encoder
    import conv_pkg::*;
#(
    parameter int         DATA_W = CONV_DATA_W,
    parameter logic [2:0] G0     = CONV_G0,
    parameter logic [2:0] G1     = CONV_G1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [DATA_W-1:0]   i_data,
    output logic [2*DATA_W-1:0] o_data,
    output logic                o_done
`ifdef ERR_INJECT_EN
    ,
    input  logic [2*DATA_W-1:0] i_err_mask
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    conv_state_e         state_q;
    logic [DATA_W-1:0]   data_q;     // remaining info bits, next bit in the MSB
    logic                s1_q;
    logic                s2_q;
    logic [CNT_W-1:0]    cnt_q;      // bits already encoded in this frame
    logic [2*DATA_W-1:0] cw_q;       // codeword under assembly, newest pair in the LSBs
    logic [2*DATA_W-1:0] o_data_q;
    logic                o_ready_q;
    logic                o_done_q;
`ifdef ERR_INJECT_EN
    logic [2*DATA_W-1:0] mask_q;
`endif

    logic                u;
    logic                c0;
    logic                c1;
    logic                s1_d;
    logic                s2_d;
    logic [2*DATA_W-1:0] cw_d;
    logic                last_bit;

    assign u = data_q[DATA_W-1];

    conv_bit_step #(
        .G0 (G0),
        .G1 (G1)
    ) u_step (
        .u_i      (u),
        .s1_i     (s1_q),
        .s2_i     (s2_q),
        .c0_o     (c0),
        .c1_o     (c1),
        .s1_nxt_o (s1_d),
        .s2_nxt_o (s2_d)
    );

    // Shifting pairs in from the right leaves pair 0 in the top two bits
    // once all DATA_W pairs are in.
    always_comb begin
        cw_d     = {cw_q[2*DATA_W-3:0], c0, c1};
        last_bit = (cnt_q == CNT_W'(DATA_W - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            cnt_q     <= '0;
            cw_q      <= '0;
            o_data_q  <= '0;
            o_ready_q <= 1'b1;
            o_done_q  <= 1'b0;
`ifdef ERR_INJECT_EN
            mask_q    <= '0;
`endif
        end else if (en) begin
            case (state_q)
                IDLE: begin
                    if (i_valid && o_ready_q) begin
                        data_q    <= i_data;
                        s1_q      <= 1'b0;
                        s2_q      <= 1'b0;
                        cnt_q     <= '0;
                        cw_q      <= '0;
                        o_ready_q <= 1'b0;
                        state_q   <= ENC;
`ifdef ERR_INJECT_EN
                        mask_q    <= i_err_mask;
`endif
                    end
                end
                ENC: begin
                    data_q <= {data_q[DATA_W-2:0], 1'b0};
                    s1_q   <= s1_d;
                    s2_q   <= s2_d;
                    cw_q   <= cw_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
`ifdef ERR_INJECT_EN
                        o_data_q <= cw_d ^ mask_q;
`else
                        o_data_q <= cw_d;
`endif
                        o_done_q <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    o_done_q  <= 1'b0;
                    o_ready_q <= 1'b1;
                    state_q   <= IDLE;
                end
                default: begin
                    o_done_q  <= 1'b0;
                    o_ready_q <= 1'b1;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign o_data  = o_data_q;
    assign o_ready = o_ready_q;
    assign o_done  = o_done_q;

endmodule : conv_frame_encoder

// File: tb/tb_conv_frame_encoder.sv
// Directed bench for conv_frame_encoder: reset, known codewords, back-to-back frames,
// enable stalls in ENC and DONE, mid-frame reset, and (with ERR_INJECT_EN) the error mask.
// Expected codewords are hand-computed for G0=111, G1=101.
module tb_conv_frame_encoder;

    localparam int DATA_W = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic                i_valid;
    logic                o_ready;
    logic [DATA_W-1:0]   i_data;
    logic [2*DATA_W-1:0] o_data;
    logic                o_done;
`ifdef ERR_INJECT_EN
    logic [2*DATA_W-1:0] i_err_mask;
`endif

    int n_cmp = 0;
    int n_err = 0;

    conv_frame_encoder #(
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data     (i_data),
        .o_data     (o_data),
        .o_done     (o_done)
`ifdef ERR_INJECT_EN
        ,
        .i_err_mask (i_err_mask)
`endif
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs and samples both sit 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Steps until o_done is seen or the budget runs out; n = edges taken.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!o_done && n < 40);
    endtask

    // Accept one frame, check hold/latency/codeword/strobe width/ready return.
    task automatic run_frame(input string tag, input logic [DATA_W-1:0] d,
                             input logic [2*DATA_W-1:0] prev, input logic [2*DATA_W-1:0] exp);
        int n;
        i_valid = 1'b1;
        i_data  = d;
        step();
        i_valid = 1'b0;
        i_data  = '0;
        check({tag, "_ready_low"}, 32'(o_ready), 32'd0);
        check({tag, "_hold_prev"}, 32'(o_data), 32'(prev));
        wait_done(n);
        check({tag, "_latency"}, 32'(n), 32'd8);
        check({tag, "_codeword"}, 32'(o_data), 32'(exp));
        step();
        check({tag, "_done_1cyc"}, 32'(o_done), 32'd0);
        check({tag, "_ready_back"}, 32'(o_ready), 32'd1);
    endtask

    initial begin
        int  n;
        bit  seen;
        rst     = 1'b1;
        en      = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
`ifdef ERR_INJECT_EN
        i_err_mask = '0;
`endif

        // 1. reset held for two cycles
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_data", 32'(o_data), 32'd0);
            check("rst_done", 32'(o_done), 32'd0);
            check("rst_ready", 32'(o_ready), 32'd1);
        end
        rst = 1'b0;
        step();

        // 2./3. single frames and back-to-back state clear
        run_frame("b0", 8'hB0, 16'h0000, 16'hE170);
        run_frame("zero", 8'h00, 16'hE170, 16'h0000);
        run_frame("ff", 8'hFF, 16'h0000, 16'hDAAA);
        run_frame("ff_b2b", 8'hFF, 16'hDAAA, 16'hDAAA);
        run_frame("b0_b2b", 8'hB0, 16'hDAAA, 16'hE170);

        // 4. en low for 3 cycles in ENC, then en low during DONE
        i_valid = 1'b1;
        i_data  = 8'hFF;
        step();
        i_valid = 1'b0;
        step(); step(); step();
        en = 1'b0;
        step(); step(); step();
        check("stall_no_done", 32'(o_done), 32'd0);
        check("stall_ready", 32'(o_ready), 32'd0);
        en = 1'b1;
        wait_done(n);
        check("stall_latency", 32'(n + 6), 32'd11);
        check("stall_codeword", 32'(o_data), 32'hDAAA);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("done_hold", 32'(o_done), 32'd1);
        end
        check("done_hold_ready", 32'(o_ready), 32'd0);
        en = 1'b1;
        step();
        check("done_release", 32'(o_done), 32'd0);
        check("done_release_ready", 32'(o_ready), 32'd1);

        // 5. reset while bit 4 of 8'hB0 is being encoded
        i_valid = 1'b1;
        i_data  = 8'hB0;
        step();
        i_valid = 1'b0;
        step(); step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_data", 32'(o_data), 32'd0);
        check("abort_ready", 32'(o_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (o_done) seen = 1'b1;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        run_frame("after_abort", 8'hFF, 16'h0000, 16'hDAAA);

`ifdef ERR_INJECT_EN
        // 6. single flipped LSB on the channel side
        i_err_mask = 16'h0001;
        run_frame("err_inj", 8'hB0, 16'hDAAA, 16'hE171);
        i_err_mask = 16'h0000;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_conv_frame_encoder
